safe_access_arbiter: RTL and testbench

SAFE_ACCESS_ARBITER -- requirements
Module: safe_access_arbiter

---
 rtl/safe_access_arbiter_if.sv | 31 +++
 rtl/safe_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_safe_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/safe_access_arbiter_if.sv
// Requester, response and safe-side signals of the safe access arbiter.
// The arbiter connects through the slave modport.
interface safe_access_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_pin;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_pin;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_ok;
    logic        safe_reset;
    logic [3:0]  safe_din;
    logic        safe_din_valid;
    logic        safe_unlocked;
    logic        busy;
    logic        lockout;

    modport master (
        output req0_valid, req0_pin, req1_valid, req1_pin, safe_unlocked,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ok,
               safe_reset, safe_din, safe_din_valid, busy, lockout
    );

    modport slave (
        input  req0_valid, req0_pin, req1_valid, req1_pin, safe_unlocked,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ok,
               safe_reset, safe_din, safe_din_valid, busy, lockout
    );
endinterface

// File: rtl/safe_access_arbiter.sv
// Arbitrates two PIN requesters onto a digit-serial safe: resets the safe, sends
// four digits, samples unlocked, responds; backs off or locks out on failures.
module safe_access_arbiter #(
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned COOLDOWN      = 8,
    parameter int unsigned MAX_FAILS     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    safe_access_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SRST, DIGIT, SETTLE, CHECK, COOL, LOCKOUT} state_t;

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [1:0]  dig, dig_d;
    logic [3:0]  fail, fail_d, fail_inc;
    logic        last, last_d;
    logic [15:0] pin, pin_d;
    logic        id, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_ok_q, rsp_ok_d;
    logic        grant0, grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dig         <= '0;
            fail        <= '0;
            last        <= 1'b1;
            pin         <= '0;
            id          <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_ok_q    <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            dig         <= dig_d;
            fail        <= fail_d;
            last        <= last_d;
            pin         <= pin_d;
            id          <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ok_q    <= rsp_ok_d;
        end
    end

    assign fail_inc = (fail == '1) ? fail : fail + 4'd1;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        dig_d       = dig;
        fail_d      = fail;
        last_d      = last;
        pin_d       = pin;
        id_d        = id;
        rsp_valid_d = 1'b0;
        rsp_id_d    = 1'b0;
        rsp_ok_d    = 1'b0;
        grant0      = 1'b0;
        grant1      = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester not served last wins (last=1 favours req0).
                if (!reset) begin
                    if (bus.req0_valid && (!bus.req1_valid || last)) grant0 = 1'b1;
                    else if (bus.req1_valid)                         grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    pin_d   = grant0 ? bus.req0_pin : bus.req1_pin;
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = 8'(RST_CYCLES - 1);
                    state_d = SRST;
                end
            end
            SRST: begin
                if (cnt == '0) begin
                    dig_d   = '0;
                    state_d = DIGIT;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            DIGIT: begin
                if (dig == 2'd3) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d   = 8'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end
                end else begin
                    dig_d = dig + 2'd1;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_d = CHECK;
                else           cnt_d   = cnt - 8'd1;
            end
            CHECK: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id;
                rsp_ok_d    = bus.safe_unlocked;
                if (bus.safe_unlocked) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    fail_d = fail_inc;
                    if (MAX_FAILS != 0 && fail_inc >= 4'(MAX_FAILS)) begin
                        state_d = LOCKOUT;
                    end else if (COOLDOWN == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = 8'(COOLDOWN - 1);
                        state_d = COOL;
                    end
                end
            end
            COOL: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 8'd1;
            end
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready     = grant0;
    assign bus.req1_ready     = grant1;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_ok         = rsp_ok_q;
    assign bus.busy           = (state != IDLE);
    assign bus.lockout        = (state == LOCKOUT);
    assign bus.safe_reset     = !(state == DIGIT || state == SETTLE || state == CHECK);
    assign bus.safe_din_valid = (state == DIGIT);

    always_comb begin
        bus.safe_din = '0;
        if (state == DIGIT) begin
            case (dig)
                2'd0:    bus.safe_din = pin[15:12];
                2'd1:    bus.safe_din = pin[11:8];
                2'd2:    bus.safe_din = pin[7:4];
                default: bus.safe_din = pin[3:0];
            endcase
        end
    end
endmodule

// File: tb/tb_safe_access_arbiter.sv
// Directed bench for safe_access_arbiter with a behavioural safe whose secret is c0de.
module tb_safe_access_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    safe_access_arbiter_if bus();

    safe_access_arbiter #(
        .RST_CYCLES(2),
        .SETTLE_CYCLES(1),
        .COOLDOWN(8),
        .MAX_FAILS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Safe model: collects digits while out of reset, unlocks on exactly c0de.
    logic [15:0] safe_sh = '0;
    int          safe_cnt = 0;
    always @(posedge clk) begin
        if (bus.safe_reset) begin
            safe_sh  <= '0;
            safe_cnt <= 0;
        end else if (bus.safe_din_valid) begin
            safe_sh  <= {safe_sh[11:0], bus.safe_din};
            safe_cnt <= safe_cnt + 1;
        end
    end
    assign bus.safe_unlocked = (safe_cnt == 4) && (safe_sh == 16'hc0de);

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_ok, bus.safe_reset, bus.safe_din,
             bus.safe_din_valid, bus.busy, bus.lockout, bus.req0_ready, bus.req1_ready}
            !== {3'b000, 1'b1, 4'h0, 1'b0, 2'b00, 2'b00}) begin
            bad++;
            $display("FAIL reset_outputs: got rv=%b id=%b ok=%b sr=%b din=%h dv=%b busy=%b lo=%b r0=%b r1=%b required 0 0 0 1 0 0 0 0 0 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_ok, bus.safe_reset, bus.safe_din,
                     bus.safe_din_valid, bus.busy, bus.lockout, bus.req0_ready, bus.req1_ready);
        end
        reset = 1'b0;
        #1;
    endtask

    // Offers a PIN in the current IDLE cycle T and checks every cycle up to the response at T+9.
    task automatic attempt(input bit who, input logic [15:0] p, input bit exp_ok);
        logic       exp_sr, exp_dv;
        logic [3:0] exp_din;
        if (who == 1'b0) begin bus.req0_valid = 1'b1; bus.req0_pin = p; end
        else             begin bus.req1_valid = 1'b1; bus.req1_pin = p; end
        #1;
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== (who ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL grant: got r0=%b r1=%b required requester %0d", bus.req0_ready, bus.req1_ready, who);
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (who == 1'b0) begin bus.req0_valid = 1'b0; bus.req0_pin = 16'hffff; end
                else             begin bus.req1_valid = 1'b0; bus.req1_pin = 16'hffff; end
            end
            #1;
            exp_sr  = (k <= 2 || k == 9);
            exp_dv  = (k >= 3 && k <= 6);
            exp_din = exp_dv ? 4'((p >> (4 * (6 - k))) & 16'h000f) : 4'h0;
            total++;
            if ({bus.safe_reset, bus.safe_din_valid, bus.safe_din} !== {exp_sr, exp_dv, exp_din}) begin
                bad++;
                $display("FAIL safe_drive T+%0d: got sr=%b dv=%b din=%h required sr=%b dv=%b din=%h",
                         k, bus.safe_reset, bus.safe_din_valid, bus.safe_din, exp_sr, exp_dv, exp_din);
            end
            total++;
            if (bus.rsp_valid !== (k == 9) ||
                (k == 9 && (bus.rsp_id !== who || bus.rsp_ok !== exp_ok))) begin
                bad++;
                $display("FAIL response T+%0d: got rv=%b id=%b ok=%b required rv=%b id=%b ok=%b",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_ok, (k == 9), who, exp_ok);
            end
            total++;
            if (bus.busy !== ((k < 9) ? 1'b1 : !exp_ok)) begin
                bad++;
                $display("FAIL busy T+%0d: got %b required %b", k, bus.busy, (k < 9) ? 1'b1 : !exp_ok);
            end
            if (k < 9) begin
                total++;
                if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                    bad++;
                    $display("FAIL ready_busy T+%0d: got r0=%b r1=%b required 0 0", k, bus.req0_ready, bus.req1_ready);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: got busy=%b after %0d cycles required 0", bus.busy, n);
        end
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1; bus.req0_pin = 16'hc0de;
        bus.req1_valid = 1'b1; bus.req1_pin = 16'hc0de;
        do_reset();
        total++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL reset_tie: got r0=%b r1=%b required 1 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        attempt(1'b0, 16'hc0de, 1'b1);
        step();
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_pulse: got rv=%b required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_pin = 16'hc0de;
        attempt(1'b0, 16'hc0de, 1'b1);
        attempt(1'b1, 16'hc0de, 1'b1);
        bus.req1_valid = 1'b1; bus.req1_pin = 16'hc0de;
        attempt(1'b0, 16'hc0de, 1'b1);
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reject_cooldown();
        do_reset();
        attempt(1'b1, 16'h1234, 1'b0);
        bus.req1_valid = 1'b1; bus.req1_pin = 16'h1234;
        #1;
        for (int k = 9; k <= 16; k++) begin
            if (k > 9) step();
            total++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                bad++;
                $display("FAIL cooldown_ready T+%0d: got r0=%b r1=%b required 0 0", k, bus.req0_ready, bus.req1_ready);
            end
        end
        step();
        attempt(1'b1, 16'hc0de, 1'b1);
    endtask

    task automatic test_lockout();
        do_reset();
        attempt(1'b0, 16'h1111, 1'b0);
        wait_idle();
        attempt(1'b1, 16'h2222, 1'b0);
        wait_idle();
        attempt(1'b0, 16'h3333, 1'b0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            total++;
            if ({bus.lockout, bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 5'b11000) begin
                bad++;
                $display("FAIL lockout_hold cycle %0d: got lo=%b busy=%b r0=%b r1=%b rv=%b required 1 1 0 0 0",
                         k, bus.lockout, bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp_valid);
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        do_reset();
        attempt(1'b0, 16'h4444, 1'b0);
        step();
        total++;
        if (bus.lockout !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL lockout_counter_clear: got lo=%b busy=%b required 0 1", bus.lockout, bus.busy);
        end
        wait_idle();
    endtask

    task automatic test_fail_clear();
        do_reset();
        attempt(1'b0, 16'h0001, 1'b0);
        wait_idle();
        attempt(1'b1, 16'h0002, 1'b0);
        wait_idle();
        attempt(1'b0, 16'hc0de, 1'b1);
        attempt(1'b1, 16'h0003, 1'b0);
        wait_idle();
        attempt(1'b0, 16'h0004, 1'b0);
        step();
        total++;
        if (bus.lockout !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL success_clears_count: got lo=%b busy=%b required 0 1", bus.lockout, bus.busy);
        end
        wait_idle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_pin = 16'hc0de;
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        step();
        total++;
        if (bus.safe_din_valid !== 1'b1 || bus.safe_din !== 4'h0) begin
            bad++;
            $display("FAIL midflight_digit: got dv=%b din=%h required 1 0", bus.safe_din_valid, bus.safe_din);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({bus.safe_reset, bus.safe_din_valid, bus.busy, bus.rsp_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL midflight_abort: got sr=%b dv=%b busy=%b rv=%b required 1 0 0 0",
                     bus.safe_reset, bus.safe_din_valid, bus.busy, bus.rsp_valid);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            total++;
            if (bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL midflight_no_rsp cycle %0d: got rv=%b required 0", k, bus.rsp_valid);
            end
        end
        attempt(1'b0, 16'hc0de, 1'b1);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_pin = '0;
        bus.req1_valid = 1'b0; bus.req1_pin = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reject_cooldown();
        test_lockout();
        test_fail_clear();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
